commit_trace_capture: RTL and testbench

// - Sits beside the cpu core and takes one commit record per retired instruction: pc, instruction and register-file write.
// - Buffers records in a FIFO and streams them out as 32-bit words over a valid/ready port.
// - Gives hardware the same per-instruction trace that simulation writes to result.txt.
// - Stops capturing after MAX_RECORDS commits.

---
 rtl/commit_trace_capture_if.sv | 33 +++
 rtl/commit_trace_capture.sv | 195 +++++++++++++++++++
 tb/tb_commit_trace_capture.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_capture_if.sv
// Commit-trace bus: the per-instruction commit record going in and the 32-bit
// trace word stream plus capture status coming out.
interface commit_trace_capture_if #(
    parameter int DROP_W = 16
);
    logic              capture_en;
    logic              commit_valid;
    logic [31:0]       commit_pc;
    logic [31:0]       commit_instr;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic              done;

    // Core / sink side: produces commits, consumes trace words.
    modport master (
        output capture_en, commit_valid, commit_pc, commit_instr,
        output rf_we, rf_waddr, rf_wdata, out_ready,
        input  out_valid, out_data, overflow, drop_count, done
    );

    // Capture block side.
    modport slave (
        input  capture_en, commit_valid, commit_pc, commit_instr,
        input  rf_we, rf_waddr, rf_wdata, out_ready,
        output out_valid, out_data, overflow, drop_count, done
    );
endinterface

// File: rtl/commit_trace_capture.sv
// Commit trace capture: buffers retired-instruction records in a FIFO and
// serialises them as 32-bit words. Optional TRACE_TIMESTAMP_EN adds a cycle stamp word.
module commit_trace_capture #(
    parameter int DEPTH       = 16,
    parameter int MAX_RECORDS = 3000,
    parameter int DROP_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    commit_trace_capture_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = $clog2(MAX_RECORDS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_W1   = 3'd2;
    localparam logic [2:0] S_W2   = 3'd3;
    localparam logic [2:0] S_W3   = 3'd4;
`ifdef TRACE_TIMESTAMP_EN
    localparam logic [2:0] S_WT   = 3'd5;
    localparam logic [2:0] S_LAST = S_WT;
`else
    localparam logic [2:0] S_LAST = S_W3;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } rec_t;

    function automatic logic [31:0] word_of(input rec_t r, input logic [2:0] st);
        logic [31:0] w;
        w = '0;
        case (st)
            S_W0:    w = r.pc;
            S_W1:    w = r.instr;
            S_W2:    w = {r.we, 26'b0, r.waddr};
            S_W3:    w = r.wdata;
`ifdef TRACE_TIMESTAMP_EN
            S_WT:    w = r.ts;
`endif
            default: w = '0;
        endcase
        return w;
    endfunction

    rec_t              mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    rec_t              hold_q, hold_d;
    logic [2:0]        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  accepted_q, accepted_d;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       ts_q, ts_d;
`endif

    logic empty, full, hs, last_hs, pop, push_req, push, drop;
    rec_t head, new_rec;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign hs       = out_valid_q & bus.out_ready;
    assign last_hs  = hs & (state_q == S_LAST);
    // The serializer refills either from idle or on the final word handshake.
    assign pop      = !empty & ((state_q == S_IDLE) | last_hs);
    assign push_req = bus.commit_valid & bus.capture_en & !done_q;
    assign push     = push_req & (!full | pop);
    assign drop     = push_req & !push;

    always_comb begin
        new_rec       = '0;
        new_rec.pc    = bus.commit_pc;
        new_rec.instr = bus.commit_instr;
        new_rec.we    = bus.rf_we;
        new_rec.waddr = bus.rf_waddr;
        new_rec.wdata = bus.rf_we ? bus.rf_wdata : 32'b0;
`ifdef TRACE_TIMESTAMP_EN
        new_rec.ts    = ts_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_W0;
                    hold_d  = head;
                end
            end
            default: begin
                if (!out_valid_q) begin
                    // First presentation of a freshly popped record.
                    out_valid_d = 1'b1;
                    out_data_d  = word_of(hold_q, state_q);
                end else if (hs) begin
                    if (state_q == S_LAST) begin
                        if (pop) begin
                            // Back-to-back: present next record's pc straight from the FIFO head.
                            state_d    = S_W0;
                            hold_d     = head;
                            out_data_d = word_of(head, S_W0);
                        end else begin
                            state_d     = S_IDLE;
                            out_valid_d = 1'b0;
                            out_data_d  = '0;
                        end
                    end else begin
                        state_d    = state_q + 3'd1;
                        out_data_d = word_of(hold_q, state_q + 3'd1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        accepted_d   = push ? accepted_q + CNT_W'(1) : accepted_q;
        done_d       = done_q | (push && (accepted_q + CNT_W'(1) == CNT_W'(MAX_RECORDS)));
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_W'(1);
        end
`ifdef TRACE_TIMESTAMP_EN
        ts_d = ts_q + 32'd1;
`endif
    end

    // Record storage has no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hold_q       <= '0;
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            done_q       <= 1'b0;
            accepted_q   <= '0;
`ifdef TRACE_TIMESTAMP_EN
            ts_q         <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_q       <= hold_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            done_q       <= done_d;
            accepted_q   <= accepted_d;
`ifdef TRACE_TIMESTAMP_EN
            ts_q         <= ts_d;
`endif
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_commit_trace_capture.sv
// Bench for commit_trace_capture: directed scenarios plus random traffic
// scored against a queue of expected trace words built from the record format.
module tb_commit_trace_capture;
`ifdef TRACE_TIMESTAMP_EN
    localparam int WPR = 5;
`else
    localparam int WPR = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    commit_trace_capture_if #(.DROP_W(16)) ifa ();
    commit_trace_capture_if #(.DROP_W(16)) ifb ();

    commit_trace_capture #(.DEPTH(16), .MAX_RECORDS(3000), .DROP_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    commit_trace_capture #(.DEPTH(16), .MAX_RECORDS(3), .DROP_W(16)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int seen_a = 0, seen_b = 0, acc_a = 0;
    logic stall_a = 1'b0, stall_b = 1'b0;
    logic [31:0] prev_a = '0, prev_b = '0;
    logic [31:0] cyc;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_push(input logic b, input logic [31:0] pc, input logic [31:0] instr,
                                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] w [5];
        w[0] = pc;
        w[1] = instr;
        w[2] = {we, 26'b0, wa};
        w[3] = we ? wd : 32'b0;
        w[4] = cyc;
        for (int i = 0; i < WPR; i++) begin
            if (b) exp_b.push_back(w[i]);
            else   exp_a.push_back(w[i]);
        end
        if (!b) acc_a++;
    endfunction

    task automatic drive_a(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ifa.commit_valid = v;  ifa.commit_pc = pc;  ifa.commit_instr = instr;
        ifa.rf_we = we;        ifa.rf_waddr = wa;   ifa.rf_wdata = wd;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ifb.commit_valid = v;  ifb.commit_pc = pc;  ifb.commit_instr = instr;
        ifb.rf_we = we;        ifb.rf_waddr = wa;   ifb.rf_wdata = wd;
    endtask

    // Score the handshakes due at the coming edge, check stall stability, advance one cycle.
    task automatic tick();
        if (stall_a) begin
            chk("a_hold_valid", 64'(ifa.out_valid), 64'(1));
            chk("a_hold_data", 64'(ifa.out_data), 64'(prev_a));
        end
        if (ifa.out_valid && ifa.out_ready) begin
            chk("a_word_expected", 64'(exp_a.size() != 0), 64'(1));
            if (exp_a.size() != 0) chk("a_word", 64'(ifa.out_data), 64'(exp_a.pop_front()));
            seen_a++;
        end
        stall_a = ifa.out_valid && !ifa.out_ready;
        prev_a  = ifa.out_data;
        if (stall_b) chk("b_hold_data", 64'(ifb.out_data), 64'(prev_b));
        if (ifb.out_valid && ifb.out_ready) begin
            chk("b_word_expected", 64'(exp_b.size() != 0), 64'(1));
            if (exp_b.size() != 0) chk("b_word", 64'(ifb.out_data), 64'(exp_b.pop_front()));
            seen_b++;
        end
        stall_b = ifb.out_valid && !ifb.out_ready;
        prev_b  = ifb.out_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_a(input string tag, input int budget);
        int n;
        n = 0;
        ifa.out_ready = 1'b1;
        while ((exp_a.size() != 0 || ifa.out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_a.size()), 64'(0));
    endtask

    // Advance with ready=1 until word index idx of the current record is presented, then stall.
    task automatic reach_word_a(input string tag, input int idx);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (n < 40 && !found) begin
            if (ifa.out_valid && (seen_a % WPR) == idx) found = 1'b1;
            else begin
                ifa.out_ready = 1'b1;
                tick();
                n++;
            end
        end
        ifa.out_ready = 1'b0;
        chk(tag, 64'(found), 64'(1));
    endtask

    initial begin
        int words0;
        logic did;
        logic v, cap, we;
        logic [31:0] pc, instr, wd;
        logic [4:0] wa;

        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        drive_b(1'b0, '0, '0, 1'b0, '0, '0);
        ifa.capture_en = 1'b1; ifa.out_ready = 1'b1;
        ifb.capture_en = 1'b1; ifb.out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(ifa.out_valid), 64'(0));
        chk("rst_out_data", 64'(ifa.out_data), 64'(0));
        chk("rst_overflow", 64'(ifa.overflow), 64'(0));
        chk("rst_drop_count", 64'(ifa.drop_count), 64'(0));
        chk("rst_done", 64'(ifa.done), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Single commit: latency and word format
        drive_a(1'b1, 32'h0040_0000, 32'h2008_0005, 1'b1, 5'd8, 32'd5);
        model_push(1'b0, 32'h0040_0000, 32'h2008_0005, 1'b1, 5'd8, 32'd5);
        tick();
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        chk("lat_after_push", 64'(ifa.out_valid), 64'(0));
        tick();
        chk("lat_after_pop", 64'(ifa.out_valid), 64'(0));
        tick();
        chk("lat_valid", 64'(ifa.out_valid), 64'(1));
        chk("single_w0", 64'(ifa.out_data), 64'(32'h0040_0000));
        drain_a("single_drained", 30);

        // Backpressure in W1, then an rf_we=0 record
        drive_a(1'b1, 32'h0040_0000, 32'h2008_0005, 1'b1, 5'd8, 32'd5);
        model_push(1'b0, 32'h0040_0000, 32'h2008_0005, 1'b1, 5'd8, 32'd5);
        tick();
        drive_a(1'b1, 32'h0040_0004, 32'h0000_0013, 1'b0, 5'd3, 32'hdead_beef);
        model_push(1'b0, 32'h0040_0004, 32'h0000_0013, 1'b0, 5'd3, 32'hdead_beef);
        tick();
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        reach_word_a("bp_reach_w1", 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_w1_held", 64'(ifa.out_data), 64'(32'h2008_0005));
        end
        drain_a("bp_drained", 40);

        // Overflow: serializer stalled on R0, then 20 commits into the FIFO
        ifa.out_ready = 1'b0;
        drive_a(1'b1, 32'h1000_0000, 32'h1111_1111, 1'b1, 5'd1, 32'h0000_00aa);
        model_push(1'b0, 32'h1000_0000, 32'h1111_1111, 1'b1, 5'd1, 32'h0000_00aa);
        tick();
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            drive_a(1'b1, 32'h2000_0000 + 32'(i * 4), 32'h3000_0000 + 32'(i), 1'(i % 2), 5'(i), 32'h4000_0000 + 32'(i));
            if (i < 16) model_push(1'b0, 32'h2000_0000 + 32'(i * 4), 32'h3000_0000 + 32'(i), 1'(i % 2), 5'(i), 32'h4000_0000 + 32'(i));
            tick();
        end
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        chk("ovf_drop_count", 64'(ifa.drop_count), 64'(4));
        chk("ovf_overflow", 64'(ifa.overflow), 64'(1));

        // Full FIFO, commit on R0's last-word handshake is accepted
        words0 = seen_a;
        did = 1'b0;
        ifa.out_ready = 1'b1;
        for (int n = 0; n < 200 && (exp_a.size() != 0 || ifa.out_valid); n++) begin
            if (!did && ifa.out_valid && (seen_a % WPR) == WPR - 1) begin
                drive_a(1'b1, 32'h5000_0000, 32'h5555_5555, 1'b1, 5'd31, 32'h6666_6666);
                model_push(1'b0, 32'h5000_0000, 32'h5555_5555, 1'b1, 5'd31, 32'h6666_6666);
                did = 1'b1;
            end else begin
                drive_a(1'b0, '0, '0, 1'b0, '0, '0);
            end
            tick();
        end
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        chk("fullpop_issued", 64'(did), 64'(1));
        chk("fullpop_drained", 64'(exp_a.size()), 64'(0));
        chk("ovf_words_emitted", 64'(seen_a - words0), 64'(18 * WPR));
        chk("fullpop_drop_same", 64'(ifa.drop_count), 64'(4));

        // Record limit on the MAX_RECORDS=3 instance
        for (int i = 0; i < 5; i++) begin
            drive_b(1'b1, 32'h7000_0000 + 32'(i * 4), 32'h7100_0000 + 32'(i), 1'b1, 5'(i + 2), 32'h7200_0000 + 32'(i));
            if (i < 3) model_push(1'b1, 32'h7000_0000 + 32'(i * 4), 32'h7100_0000 + 32'(i), 1'b1, 5'(i + 2), 32'h7200_0000 + 32'(i));
            tick();
            chk("limit_done", 64'(ifb.done), 64'(i >= 2));
        end
        drive_b(1'b0, '0, '0, 1'b0, '0, '0);
        for (int n = 0; n < 60; n++) tick();
        chk("limit_drained", 64'(exp_b.size()), 64'(0));
        chk("limit_words", 64'(seen_b), 64'(3 * WPR));
        chk("limit_drop_zero", 64'(ifb.drop_count), 64'(0));

        // Random traffic against the word-queue model
        for (int n = 0; n < 600; n++) begin
            cap   = ($urandom_range(0, 7) != 0);
            v     = ($urandom_range(0, 2) == 0) && (acc_a - seen_a / WPR < 15);
            pc    = $urandom & 32'hffff_fffc;
            instr = $urandom;
            we    = 1'($urandom_range(0, 1));
            wa    = 5'($urandom_range(0, 31));
            wd    = $urandom;
            ifa.capture_en = cap;
            ifa.out_ready  = ($urandom_range(0, 3) != 0);
            drive_a(v, pc, instr, we, wa, wd);
            if (v && cap) model_push(1'b0, pc, instr, we, wa, wd);
            tick();
        end
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        ifa.capture_en = 1'b1;
        drain_a("rand_drained", 600);
        chk("rand_no_new_drops", 64'(ifa.drop_count), 64'(4));

        // Reset while stalled in W2
        drive_a(1'b1, 32'h0800_0000, 32'h0123_4567, 1'b1, 5'd9, 32'h89ab_cdef);
        model_push(1'b0, 32'h0800_0000, 32'h0123_4567, 1'b1, 5'd9, 32'h89ab_cdef);
        ifa.out_ready = 1'b0;
        tick();
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        reach_word_a("rst_reach_w2", 2);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ifa.out_valid), 64'(0));
        chk("midrst_out_data", 64'(ifa.out_data), 64'(0));
        chk("midrst_overflow", 64'(ifa.overflow), 64'(0));
        chk("midrst_drop_count", 64'(ifa.drop_count), 64'(0));
        chk("midrst_done", 64'(ifb.done), 64'(0));
        exp_a.delete(); exp_b.delete();
        seen_a = 0; seen_b = 0; acc_a = 0;
        stall_a = 1'b0; stall_b = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive_a(1'b1, 32'h0900_0000, 32'h0abc_def0, 1'b0, 5'd4, 32'h1234_5678);
        model_push(1'b0, 32'h0900_0000, 32'h0abc_def0, 1'b0, 5'd4, 32'h1234_5678);
        tick();
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        tick(); tick(); tick();
        drive_a(1'b1, 32'h0900_0004, 32'h0abc_def4, 1'b1, 5'd5, 32'h1234_0000);
        model_push(1'b0, 32'h0900_0004, 32'h0abc_def4, 1'b1, 5'd5, 32'h1234_0000);
        tick();
        drive_a(1'b0, '0, '0, 1'b0, '0, '0);
        ifa.out_ready = 1'b0;
        chk("postrst_w0", 64'(ifa.out_data), 64'(32'h0900_0000));
        drain_a("postrst_drained", 40);
        chk("postrst_words", 64'(seen_a), 64'(2 * WPR));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
